// File: rtl/avoid_drive_ctrl_pkg.sv
// Shared types and helpers for the obstacle-avoidance drive controller:
// mode encoding, speed-switch decode, near-flag hysteresis and servo defaults.
package avoid_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CRUISE  = 3'd1,
      AVOID_L = 3'd2,
      AVOID_R = 3'd3,
      BRAKE   = 3'd4,
      FLAME   = 3'd5
   } mode_e;

   localparam int SRV_C_DEF = 70000;
   localparam int SRV_L_DEF = 55000;
   localparam int SRV_R_DEF = 85000;

   // Only thermometer codes select a graded speed; anything else is a wiring fault.
   function automatic int unsigned speed_duty(input logic [3:0] sel, input int unsigned base,
                                              input int unsigned step, input int unsigned safe);
      case (sel)
         4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111:
            speed_duty = base + step * 32'($countones(sel));
         default:
            speed_duty = safe;
      endcase
   endfunction

   function automatic logic hyst_flag(input logic cur, input logic [31:0] v,
                                      input int unsigned th, input int unsigned hy);
      if (v < th)
         hyst_flag = 1'b1;
      else if (v >= th + hy)
         hyst_flag = 1'b0;
      else
         hyst_flag = cur;
   endfunction

endpackage

// File: rtl/avoid_drive_ctrl_pwm_gen.sv
// Period counter with a shadow duty register that only loads on the wrap cycle,
// so a duty change never truncates or stretches a pulse in flight.
module pwm_gen #(
   parameter int PERIOD   = 5000,
   parameter int DW       = 13,
   parameter int RST_DUTY = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          kill,
   input  logic [DW-1:0] duty_i,
   output logic [DW-1:0] duty_o,
   output logic          pwm_o,
   output logic          wrap_o
);
   localparam int CW = $clog2(PERIOD);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] duty_q, duty_d;

   assign wrap_o = (cnt_q == CW'(PERIOD - 1));

   always_comb begin
      cnt_d  = wrap_o ? '0 : cnt_q + CW'(1);
      duty_d = duty_q;
      if (wrap_o)
         duty_d = duty_i;
      if (kill)
         duty_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         duty_q <= DW'(RST_DUTY);
      end else begin
         cnt_q  <= cnt_d;
         duty_q <= duty_d;
      end
   end

   assign duty_o = duty_q;
   assign pwm_o  = (32'(cnt_q) < 32'(duty_q));

endmodule

// File: rtl/avoid_drive_ctrl.sv
// Obstacle-avoidance drive/steer controller: mode FSM, wheel H-bridge PWM and
// slew-limited steering servo. Optional echo watchdog built when WATCHDOG_EN is defined.
module avoid_drive_ctrl
   import avoid_pkg::*;
#(
   parameter int DIST_W       = 21,
   parameter int N_FIRE       = 4,
   parameter int WHEEL_PERIOD = 5000,
   parameter int SERVO_PERIOD = 1000000,
   parameter int NEAR_TH      = 150,
   parameter int STOP_TH      = 30,
   parameter int HYST         = 10,
   parameter int BASE_DUTY    = 440,
   parameter int SPEED_STEP   = 10,
   parameter int SAFE_DUTY    = 200,
   parameter int REV_DUTY     = 300,
   parameter int SRV_C        = SRV_C_DEF,
   parameter int SRV_L        = SRV_L_DEF,
   parameter int SRV_R        = SRV_R_DEF,
   parameter int SLEW_STEP    = 2000,
   parameter int DWELL        = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              echo_valid,
   input  logic [DIST_W-1:0] left_echo,
   input  logic [DIST_W-1:0] mid_echo,
   input  logic [DIST_W-1:0] right_echo,
   input  logic [N_FIRE-1:0] fire,
   input  logic [3:0]        speed_sel,
   output logic              motor_fwd_pwm,
   output logic              motor_rev_pwm,
   output logic              steer_pwm,
   output logic [2:0]        mode,
   output logic              echo_timeout
);
   localparam int WDW = $clog2(WHEEL_PERIOD + 1);
   localparam int SDW = $clog2(SERVO_PERIOD + 1);
   localparam int DWC = $clog2(DWELL + 2);

   mode_e          state_q, state_d;
   logic [DWC-1:0] dwell_q, dwell_d;
   logic [1:0]     stop_cnt_q, stop_cnt_d;
   logic           dir_q, dir_d;
   logic           near_l_q, near_l_d, near_m_q, near_m_d, near_r_q, near_r_d;
   logic           stop_m_q, stop_m_d;

   logic           timeout, whl_wrap, whl_pwm, srv_wrap, srv_pwm;
   logic [WDW-1:0] whl_duty, whl_shadow;
   logic [SDW-1:0] pulse_w, pulse_nxt, tgt;
   logic           any_near, in_avoid, dwell_done, fire_low, rev_sel;
   logic [31:0]    cur_w, tgt_w, diff_w, step_w, nxt_w;

`ifdef WATCHDOG_EN
   localparam int WDT = 3 * SERVO_PERIOD;
   localparam int WCW = $clog2(WDT + 1);
   logic [WCW-1:0] wd_cnt_q, wd_cnt_d;
   logic           wd_to_q, wd_to_d;

   always_comb begin
      wd_cnt_d = wd_cnt_q;
      wd_to_d  = wd_to_q;
      if (echo_valid) begin
         wd_cnt_d = '0;
         wd_to_d  = 1'b0;
      end else begin
         if (wd_cnt_q != WCW'(WDT))
            wd_cnt_d = wd_cnt_q + WCW'(1);
         wd_to_d = wd_to_q | (wd_cnt_d == WCW'(WDT));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt_q <= '0;
         wd_to_q  <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         wd_to_q  <= wd_to_d;
      end
   end

   assign timeout = wd_to_q;
`else
   assign timeout = 1'b0;
`endif

   assign any_near   = near_l_q | near_r_q | near_m_q;
   assign in_avoid   = (state_q == AVOID_L) || (state_q == AVOID_R);
   assign dwell_done = (dwell_q == DWC'(DWELL + 1));
   assign fire_low   = ~&fire;

   always_comb begin
      near_l_d = near_l_q;
      near_m_d = near_m_q;
      near_r_d = near_r_q;
      stop_m_d = stop_m_q;
      if (echo_valid) begin
         near_l_d = hyst_flag(near_l_q, 32'(left_echo),  NEAR_TH, HYST);
         near_m_d = hyst_flag(near_m_q, 32'(mid_echo),   NEAR_TH, HYST);
         near_r_d = hyst_flag(near_r_q, 32'(right_echo), NEAR_TH, HYST);
         stop_m_d = hyst_flag(stop_m_q, 32'(mid_echo),   STOP_TH, HYST);
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable)
         state_d = IDLE;
      else if (timeout)
         state_d = BRAKE;
      else if (state_q == IDLE)
         state_d = CRUISE;
      else if (stop_m_q || (near_l_q && near_r_q && near_m_q))
         state_d = BRAKE;
      else if (state_q == BRAKE)
         state_d = any_near ? BRAKE : CRUISE;
      else if (in_avoid && !dwell_done)
         state_d = state_q;
      else if (near_l_q && !near_r_q)
         state_d = AVOID_R;
      else if ((near_r_q && !near_l_q) || (near_m_q && !near_l_q && !near_r_q))
         state_d = AVOID_L;
      else if (fire_low && !any_near)
         state_d = FLAME;
      else
         state_d = CRUISE;

      // Dwell counts wheel wraps; the first wrap only closes the partial entry period.
      dwell_d = dwell_q;
      if (state_d != state_q)
         dwell_d = '0;
      else if (in_avoid && whl_wrap && !dwell_done)
         dwell_d = dwell_q + DWC'(1);

      stop_cnt_d = '0;
      if (state_q == BRAKE && stop_m_q)
         stop_cnt_d = (whl_wrap && stop_cnt_q != 2'd2) ? stop_cnt_q + 2'd1 : stop_cnt_q;
   end

   always_comb begin
      whl_duty = '0;
      rev_sel  = 1'b0;
      case (state_q)
         BRAKE: begin
            rev_sel = 1'b1;
            if (!timeout && stop_cnt_q < 2'd2)
               whl_duty = WDW'(REV_DUTY);
         end
         CRUISE, AVOID_L, AVOID_R:
            whl_duty = WDW'(speed_duty(speed_sel, BASE_DUTY, SPEED_STEP, SAFE_DUTY));
         FLAME:
            whl_duty = WDW'(SAFE_DUTY);
         default: ;
      endcase
      dir_d = whl_wrap ? rev_sel : dir_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         dwell_q    <= '0;
         stop_cnt_q <= '0;
         dir_q      <= 1'b0;
         near_l_q   <= 1'b0;
         near_m_q   <= 1'b0;
         near_r_q   <= 1'b0;
         stop_m_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         dwell_q    <= dwell_d;
         stop_cnt_q <= stop_cnt_d;
         dir_q      <= dir_d;
         near_l_q   <= near_l_d;
         near_m_q   <= near_m_d;
         near_r_q   <= near_r_d;
         stop_m_q   <= stop_m_d;
      end
   end

   always_comb begin
      tgt = SDW'(SRV_C);
      case (state_q)
         AVOID_R: tgt = SDW'(SRV_R);
         AVOID_L: tgt = SDW'(SRV_L);
         FLAME: begin
            if (!fire[1] || !fire[2]) tgt = SDW'(SRV_C);
            else if (!fire[0])        tgt = SDW'(SRV_R);
            else if (!fire[3])        tgt = SDW'(SRV_L);
            else                      tgt = SDW'(SRV_C);
         end
         default: ;
      endcase
      if (timeout)
         tgt = SDW'(SRV_C);

      // Step never passes the target, so the result stays between cur and tgt.
      cur_w = 32'(pulse_w);
      tgt_w = 32'(tgt);
      if (tgt_w >= cur_w) begin
         diff_w = tgt_w - cur_w;
         step_w = (diff_w > 32'(SLEW_STEP)) ? 32'(SLEW_STEP) : diff_w;
         nxt_w  = cur_w + step_w;
      end else begin
         diff_w = cur_w - tgt_w;
         step_w = (diff_w > 32'(SLEW_STEP)) ? 32'(SLEW_STEP) : diff_w;
         nxt_w  = cur_w - step_w;
      end
      pulse_nxt = SDW'(nxt_w);
   end

   pwm_gen #(.PERIOD(WHEEL_PERIOD), .DW(WDW), .RST_DUTY(0)) u_wheel (
      .clk    (clk),
      .rst    (rst),
      .kill   (!enable || timeout),
      .duty_i (whl_duty),
      .duty_o (whl_shadow),
      .pwm_o  (whl_pwm),
      .wrap_o (whl_wrap)
   );

   pwm_gen #(.PERIOD(SERVO_PERIOD), .DW(SDW), .RST_DUTY(SRV_C)) u_servo (
      .clk    (clk),
      .rst    (rst),
      .kill   (1'b0),
      .duty_i (pulse_nxt),
      .duty_o (pulse_w),
      .pwm_o  (srv_pwm),
      .wrap_o (srv_wrap)
   );

   logic unused_sig;
   assign unused_sig = &{1'b0, srv_wrap, whl_shadow};

   // Direction is a single shadow bit, so the two legs can never overlap.
   assign motor_fwd_pwm = whl_pwm & ~dir_q;
   assign motor_rev_pwm = whl_pwm & dir_q;
   assign steer_pwm     = srv_pwm & ~rst;
   assign mode          = state_q;
   assign echo_timeout  = timeout;

endmodule

// File: tb/tb_avoid_drive_ctrl.sv
// Directed bench for avoid_drive_ctrl with a scoreboard of expected measurements.
module tb_avoid_drive_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        echo_valid = 1'b0;
   logic [20:0] left_echo = 21'd200, mid_echo = 21'd200, right_echo = 21'd200;
   logic [3:0]  fire = 4'b1111;
   logic [3:0]  speed_sel = 4'b0111;
   logic        fwd, rev, steer, eto;
   logic [2:0]  mode;
   logic        s_fwd, s_rev, s_steer, s_eto;
   logic [2:0]  s_mode;

   always #5 clk = ~clk;

   avoid_drive_ctrl #(
      .WHEEL_PERIOD(100), .SERVO_PERIOD(1000), .BASE_DUTY(44), .SPEED_STEP(1),
      .SAFE_DUTY(20), .REV_DUTY(30), .SRV_C(700), .SRV_L(550), .SRV_R(850),
      .SLEW_STEP(2000)
   ) u_dut (
      .clk(clk), .rst(rst), .enable(enable), .echo_valid(echo_valid),
      .left_echo(left_echo), .mid_echo(mid_echo), .right_echo(right_echo),
      .fire(fire), .speed_sel(speed_sel), .motor_fwd_pwm(fwd), .motor_rev_pwm(rev),
      .steer_pwm(steer), .mode(mode), .echo_timeout(eto)
   );

   avoid_drive_ctrl #(
      .WHEEL_PERIOD(100), .SERVO_PERIOD(1000), .BASE_DUTY(44), .SPEED_STEP(1),
      .SAFE_DUTY(20), .REV_DUTY(30), .SRV_C(700), .SRV_L(550), .SRV_R(850),
      .SLEW_STEP(50)
   ) u_slew (
      .clk(clk), .rst(rst), .enable(enable), .echo_valid(echo_valid),
      .left_echo(left_echo), .mid_echo(mid_echo), .right_echo(right_echo),
      .fire(fire), .speed_sel(speed_sel), .motor_fwd_pwm(s_fwd), .motor_rev_pwm(s_rev),
      .steer_pwm(s_steer), .mode(s_mode), .echo_timeout(s_eto)
   );

   // k mirrors the period counters: k % 100 = wheel count, k % 1000 = frame count
   int k;
   always @(posedge clk or posedge rst)
      if (rst) k <= 0;
      else     k <= k + 1;

   int both_cnt = 0;
   always @(negedge clk)
      if (fwd && rev) both_cnt = both_cnt + 1;

   logic ev_req = 1'b0;
   logic auto_ev = 1'b1;
   int   ev_gap = 0;
   initial begin
      forever begin
         @(negedge clk);
         echo_valid = 1'b0;
         ev_gap = ev_gap + 1;
         if (ev_req || (auto_ev && ev_gap >= 400)) begin
            echo_valid = 1'b1;
            ev_req = 1'b0;
            ev_gap = 0;
         end
      end
   end

   typedef struct { string tag; int exp; } sb_t;
   sb_t sb_q[$];
   int tests = 0;
   int fails = 0;

   task automatic push(input string t, input int e);
      sb_t x;
      x.tag = t;
      x.exp = e;
      sb_q.push_back(x);
   endtask

   task automatic check(input int obs);
      sb_t x;
      tests++;
      if (sb_q.size() == 0) begin
         fails++;
         $error("FAIL sb_empty observed=%0d", obs);
      end else begin
         x = sb_q.pop_front();
         assert (obs === x.exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", x.tag, obs, x.exp);
         end
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic set_echo(input int l, input int m, input int r);
      left_echo  = 21'(l);
      mid_echo   = 21'(m);
      right_echo = 21'(r);
      ev_req = 1'b1;
      wait (ev_req == 1'b0);
      cycles(3);
   endtask

   task automatic measure_wheel(output int f, output int r);
      f = 0;
      r = 0;
      do @(negedge clk); while (k % 100 != 0);
      for (int i = 0; i < 100; i++) begin
         f += int'(fwd);
         r += int'(rev);
         if (i < 99) @(negedge clk);
      end
   endtask

   task automatic measure_servo(output int s0, output int s1);
      s0 = 0;
      s1 = 0;
      do @(negedge clk); while (k % 1000 != 0);
      for (int i = 0; i < 1000; i++) begin
         s0 += int'(steer);
         s1 += int'(s_steer);
         if (i < 999) @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
   endtask

   initial begin
      int f, r, s0, s1;
      cycles(3);
      push("rst_mode", 0);   check(int'(mode));
      push("rst_fwd", 0);    check(int'(fwd));
      push("rst_rev", 0);    check(int'(rev));
      push("rst_steer", 0);  check(int'(steer));
      push("rst_timeout", 0); check(int'(eto));
      rst = 1'b0;

      // cruise at speed 0111
      enable = 1'b1;
      set_echo(200, 200, 200);
      push("cruise_mode", 1); check(int'(mode));
      push("cruise_fwd", 47); push("cruise_rev", 0);
      measure_wheel(f, r); check(f); check(r);
      push("cruise_steer", 700); push("cruise_steer_slew", 700);
      measure_servo(s0, s1); check(s0); check(s1);

      // left obstacle with hysteresis
      set_echo(140, 200, 200);
      push("avoid_r_mode", 3); check(int'(mode));
      push("avoid_fwd", 47);
      measure_wheel(f, r); check(f);
      push("avoid_r_steer", 850);
      measure_servo(s0, s1); check(s0);
      set_echo(155, 200, 200);
      push("hyst_hold_mode", 3); check(int'(mode));
      set_echo(160, 200, 200);
      push("hyst_release_mode", 1); check(int'(mode));

      // dwell holds AVOID_L against a swap request, then swaps
      set_echo(200, 200, 140);
      push("avoid_l_mode", 2); check(int'(mode));
      set_echo(140, 200, 200);
      cycles(200);
      push("dwell_hold_mode", 2); check(int'(mode));
      cycles(400);
      push("dwell_swap_mode", 3); check(int'(mode));
      set_echo(200, 200, 200);
      cycles(600);
      push("dwell_exit_mode", 1); check(int'(mode));

      // slew limit from a fresh centre position
      do_reset();
      set_echo(200, 200, 140);
      push("slew_mode", 2); check(int'(s_mode));
      push("slew_f1", 650); push("fast_f1", 550);
      measure_servo(s0, s1); check(s1); check(s0);
      push("slew_f2", 600); push("fast_f2", 550);
      measure_servo(s0, s1); check(s1); check(s0);
      push("slew_f3", 550);
      measure_servo(s0, s1); check(s1);
      push("slew_f4", 550);
      measure_servo(s0, s1); check(s1);

      // hard stop, flame ignored while braking
      do @(negedge clk); while (k % 100 != 10);
      set_echo(200, 25, 200);
      push("brake_mode", 4); check(int'(mode));
      fire = 4'b1110;
      cycles(5);
      push("brake_fire_mode", 4); check(int'(mode));
      push("brake_p1_fwd", 0); push("brake_p1_rev", 30);
      measure_wheel(f, r); check(f); check(r);
      push("brake_p2_rev", 30);
      measure_wheel(f, r); check(r);
      push("brake_p3_fwd", 0); push("brake_p3_rev", 0);
      measure_wheel(f, r); check(f); check(r);

      // flame steering and illegal speed code
      set_echo(200, 200, 200);
      push("flame_mode", 5); check(int'(mode));
      push("flame_fwd", 20); push("flame_rev", 0);
      measure_wheel(f, r); check(f); check(r);
      push("flame_steer", 850);
      measure_servo(s0, s1); check(s0);
      fire = 4'b1111;
      speed_sel = 4'b0101;
      cycles(3);
      push("illegal_mode", 1); check(int'(mode));
      push("illegal_fwd", 20);
      measure_wheel(f, r); check(f);
      speed_sel = 4'b1111;
      push("speed_1111_fwd", 48);
      measure_wheel(f, r); check(f);
      speed_sel = 4'b0000;
      push("speed_0000_fwd", 44);
      measure_wheel(f, r); check(f);

      // async reset mid-period
      do @(negedge clk); while (k % 1000 != 5);
      push("pre_rst_fwd", 1); check(int'(fwd));
      push("pre_rst_steer", 1); check(int'(steer));
      #1 rst = 1'b1;
      #1;
      push("async_fwd", 0);   check(int'(fwd));
      push("async_rev", 0);   check(int'(rev));
      push("async_steer", 0); check(int'(steer));
      push("async_mode", 0);  check(int'(mode));
      @(negedge clk);
      rst = 1'b0;

      // echo watchdog
      auto_ev = 1'b0;
      set_echo(200, 200, 200);
`ifdef WATCHDOG_EN
      for (int i = 0; i < 3200 && !eto; i++) @(negedge clk);
      push("wd_timeout", 1); check(int'(eto));
      cycles(3);
      push("wd_mode", 4); check(int'(mode));
      push("wd_fwd", 0); push("wd_rev", 0);
      measure_wheel(f, r); check(f); check(r);
      set_echo(200, 200, 200);
      push("wd_clear", 0); check(int'(eto));
`else
      cycles(3200);
      push("no_wd_timeout", 0); check(int'(eto));
      push("no_wd_mode", 1); check(int'(mode));
`endif
      auto_ev = 1'b1;

      push("legs_exclusive", 0); check(both_cnt);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
